bp_perf_ctrl: RTL and testbench

BP_PERF_CTRL -- requirements
Module: bp_perf_ctrl

---
 rtl/bp_perf_ctrl.sv | 149 ++++++++++++++
 tb/tb_bp_perf_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_perf_ctrl.sv
// Branch-predictor performance monitor: counts cycles, resolved branches and mispredicts
// over a measurement run, then streams the three counters out over a valid/ready port.
module bp_perf_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] HALT_INSN = 32'h0000_0073,
   parameter int unsigned DRAIN_CYC = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             br_instr_i,
   input  logic             br_miss_i,
   input  logic [31:0]      instr_i,
   output logic             busy_o,
   output logic             rpt_valid_o,
   input  logic             rpt_ready_i,
   output logic [1:0]       rpt_idx_o,
   output logic [CNT_W-1:0] rpt_data_o,
   output logic             done_o,
   output logic             sat_o
);

   localparam int unsigned DCW = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cycle_cnt, br_cnt, miss_cnt;
   logic [CNT_W-1:0] cycle_nxt, br_nxt, miss_nxt, data_nxt;
   logic [DCW-1:0]   drain_cnt, drain_nxt;
   logic [1:0]       idx_nxt;
   logic             busy_nxt, valid_nxt, done_nxt, sat_nxt;
   logic             counting;

   // State, counters and all outputs are registered here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cycle_cnt   <= '0;
         br_cnt      <= '0;
         miss_cnt    <= '0;
         drain_cnt   <= '0;
         rpt_idx_o   <= '0;
         rpt_data_o  <= '0;
         busy_o      <= 1'b0;
         rpt_valid_o <= 1'b0;
         done_o      <= 1'b0;
         sat_o       <= 1'b0;
      end else begin
         state       <= state_nxt;
         cycle_cnt   <= cycle_nxt;
         br_cnt      <= br_nxt;
         miss_cnt    <= miss_nxt;
         drain_cnt   <= drain_nxt;
         rpt_idx_o   <= idx_nxt;
         rpt_data_o  <= data_nxt;
         busy_o      <= busy_nxt;
         rpt_valid_o <= valid_nxt;
         done_o      <= done_nxt;
         sat_o       <= sat_nxt;
      end
   end

   // Next-state, counter update and next output values.
   always_comb begin
      state_nxt = state;
      cycle_nxt = cycle_cnt;
      br_nxt    = br_cnt;
      miss_nxt  = miss_cnt;
      drain_nxt = drain_cnt;
      idx_nxt   = rpt_idx_o;
      sat_nxt   = sat_o;
      done_nxt  = 1'b0;
      counting  = 1'b0;
      data_nxt  = '0;

      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = RUN;
               cycle_nxt = '0;
               br_nxt    = '0;
               miss_nxt  = '0;
               sat_nxt   = 1'b0;
            end
         end
         RUN: begin
            counting = 1'b1;
            if (stop_i || (instr_i == HALT_INSN)) begin
               state_nxt = DRAIN;
               drain_nxt = DCW'(DRAIN_CYC - 1);
            end
         end
         DRAIN: begin
            counting = 1'b1;
            if (drain_cnt == '0) begin
               state_nxt = REPORT;
               idx_nxt   = 2'd0;
            end else begin
               drain_nxt = drain_cnt - DCW'(1);
            end
         end
         REPORT: begin
            if (rpt_valid_o && rpt_ready_i) begin
               if (rpt_idx_o == 2'd2) begin
                  state_nxt = IDLE;
                  idx_nxt   = 2'd0;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt = rpt_idx_o + 2'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Saturating increments; an increment that would wrap raises the sticky flag instead.
      if (counting) begin
         if (cycle_cnt == CNT_MAX) sat_nxt = 1'b1;
         else                      cycle_nxt = cycle_cnt + CNT_W'(1);
         if (br_instr_i) begin
            if (br_cnt == CNT_MAX) sat_nxt = 1'b1;
            else                   br_nxt = br_cnt + CNT_W'(1);
         end
         if (br_instr_i && br_miss_i) begin
            if (miss_cnt == CNT_MAX) sat_nxt = 1'b1;
            else                     miss_nxt = miss_cnt + CNT_W'(1);
         end
      end

      case (idx_nxt)
         2'd0:    data_nxt = cycle_nxt;
         2'd1:    data_nxt = br_nxt;
         2'd2:    data_nxt = miss_nxt;
         default: data_nxt = '0;
      endcase

      busy_nxt  = (state_nxt == RUN) || (state_nxt == DRAIN);
      valid_nxt = (state_nxt == REPORT);
   end

endmodule

// File: tb/tb_bp_perf_ctrl.sv
// Bench for bp_perf_ctrl: a 32-bit and a 4-bit instance share stimulus and are checked
// every cycle against a run/drain/report model built from plain integer counts.
module tb_bp_perf_ctrl;

   localparam logic [31:0] HALT = 32'h0000_0073;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam int          DRAIN_CYC = 4;
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_REPORT = 3;

   logic        clk;
   logic        rst, start, stop, br_instr, br_miss, ready;
   logic [31:0] instr;
   logic        busy, valid, done, sat;
   logic [1:0]  idx;
   logic [31:0] data;
   logic        busy4, valid4, done4, sat4;
   logic [1:0]  idx4;
   logic [3:0]  data4;

   bp_perf_ctrl #(.CNT_W(32), .HALT_INSN(HALT), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
      .br_instr_i(br_instr), .br_miss_i(br_miss), .instr_i(instr),
      .busy_o(busy), .rpt_valid_o(valid), .rpt_ready_i(ready),
      .rpt_idx_o(idx), .rpt_data_o(data), .done_o(done), .sat_o(sat));

   bp_perf_ctrl #(.CNT_W(4), .HALT_INSN(HALT), .DRAIN_CYC(DRAIN_CYC)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
      .br_instr_i(br_instr), .br_miss_i(br_miss), .instr_i(instr),
      .busy_o(busy4), .rpt_valid_o(valid4), .rpt_ready_i(ready),
      .rpt_idx_o(idx4), .rpt_data_o(data4), .done_o(done4), .sat_o(sat4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0, n_bad = 0;
   int     m_phase, m_left, m_rep;
   longint m_cyc, m_br, m_miss;
   bit     m_done;
   longint cap32[$], cap4[$];
   int     done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint lim(input int w);
      return (longint'(1) << w) - 1;
   endfunction

   function automatic longint m_cnt(input int i);
      if (i == 0) return m_cyc;
      if (i == 1) return m_br;
      return m_miss;
   endfunction

   function automatic longint capv(input longint v, input int w);
      return (v > lim(w)) ? lim(w) : v;
   endfunction

   function automatic bit m_sat(input int w);
      return (m_cyc > lim(w)) || (m_br > lim(w)) || (m_miss > lim(w));
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_rep = 0;
      m_cyc = 0; m_br = 0; m_miss = 0; m_done = 1'b0;
   endtask

   task automatic model_count();
      m_cyc++;
      if (br_instr) m_br++;
      if (br_instr && br_miss) m_miss++;
   endtask

   // Advance the model by one clock edge using the inputs that were stable before it.
   task automatic model_update();
      if (rst) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      case (m_phase)
         P_IDLE: if (start) begin
            m_phase = P_RUN; m_cyc = 0; m_br = 0; m_miss = 0;
         end
         P_RUN: begin
            model_count();
            if (stop || instr == HALT) begin
               m_phase = P_DRAIN; m_left = DRAIN_CYC;
            end
         end
         P_DRAIN: begin
            model_count();
            m_left--;
            if (m_left == 0) begin
               m_phase = P_REPORT; m_rep = 0;
            end
         end
         default: if (ready) begin
            if (m_rep == 2) begin
               m_phase = P_IDLE; m_rep = 0; m_done = 1'b1;
            end else m_rep++;
         end
      endcase
   endtask

   task automatic compare_all();
      chk("busy",  64'(busy),  64'(m_phase == P_RUN || m_phase == P_DRAIN));
      chk("valid", 64'(valid), 64'(m_phase == P_REPORT));
      chk("done",  64'(done),  64'(m_done));
      chk("sat",   64'(sat),   64'(m_sat(32)));
      chk("busy4", 64'(busy4), 64'(m_phase == P_RUN || m_phase == P_DRAIN));
      chk("valid4",64'(valid4),64'(m_phase == P_REPORT));
      chk("done4", 64'(done4), 64'(m_done));
      chk("sat4",  64'(sat4),  64'(m_sat(4)));
      if (m_phase == P_REPORT) begin
         chk("idx",   64'(idx),   64'(m_rep));
         chk("data",  64'(data),  64'(capv(m_cnt(m_rep), 32)));
         chk("idx4",  64'(idx4),  64'(m_rep));
         chk("data4", 64'(data4), 64'(capv(m_cnt(m_rep), 4)));
      end
   endtask

   // One clock: check outputs mid-cycle, log handshakes, then step the model at the edge.
   task automatic tick();
      @(negedge clk);
      compare_all();
      if (valid && ready) begin
         cap32.push_back(longint'(data));
         cap4.push_back(longint'(data4));
      end
      if (done) done_cnt++;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; stop = 1'b0; br_instr = 1'b0; br_miss = 1'b0; instr = NOP;
   endtask

   task automatic run_cyc(input bit b, input bit m, input bit s, input bit h);
      br_instr = b; br_miss = m; stop = s; instr = h ? HALT : NOP;
      tick();
      idle_inputs();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < 60 && done_cnt == d0; k++) tick();
      chk(name, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic check_report(input string name, input int base, input longint e0,
                               input longint e1, input longint e2, input bit use4);
      longint e[3];
      e[0] = e0; e[1] = e1; e[2] = e2;
      chk({name, "_handshakes"}, 64'(cap32.size() - base), 64'd3);
      if (cap32.size() >= base + 3) begin
         for (int k = 0; k < 3; k++) begin
            if (use4) chk({name, "_word4"}, 64'(cap4[base + k]), 64'(e[k]));
            else      chk({name, "_word"},  64'(cap32[base + k]), 64'(e[k]));
         end
      end
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #1;
      chk({name, "_busy"},  64'({busy, busy4}),   64'd0);
      chk({name, "_valid"}, 64'({valid, valid4}), 64'd0);
      chk({name, "_done"},  64'({done, done4}),   64'd0);
      chk({name, "_sat"},   64'({sat, sat4}),     64'd0);
      chk({name, "_idx"},   64'({idx, idx4}),     64'd0);
      chk({name, "_data"},  64'({data, data4}),   64'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int     base, d0;
      longint bp_exp[3];
      rst = 1'b1; ready = 1'b0;
      idle_inputs();
      model_reset();
      tick();
      tick();
      chk("por_busy", 64'(busy), 64'd0);
      chk("por_data", 64'(data), 64'd0);
      rst = 1'b0;
      tick();
      tick();

      // Basic run: 11 RUN cycles (HALT on the last) plus 4 DRAIN cycles.
      ready = 1'b1; base = cap32.size(); d0 = done_cnt;
      do_start();
      for (int i = 0; i < 10; i++) run_cyc(i == 2 || i == 5 || i == 7, i == 5, 1'b0, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b0, 1'b1);
      wait_done("basic_done");
      tick();
      tick();
      chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
      check_report("basic", base, 15, 3, 1, 1'b0);

      // Backpressure: five stalled cycles at each index.
      ready = 1'b0; base = cap32.size();
      bp_exp[0] = 9; bp_exp[1] = 2; bp_exp[2] = 1;
      do_start();
      for (int i = 0; i < 5; i++) run_cyc(i == 1 || i == 3, i == 3, i == 4, 1'b0);
      for (int k = 0; k < 20 && !valid; k++) tick();
      for (int k = 0; k < 3; k++) begin
         repeat (5) tick();
         chk("bp_idx", 64'(idx), 64'(k));
         chk("bp_data", 64'(data), 64'(bp_exp[k]));
         ready = 1'b1;
         tick();
         ready = 1'b0;
      end
      wait_done("bp_done");
      check_report("bp", base, 9, 2, 1, 1'b0);

      // Orphan miss ignored, DRAIN branch counted, REPORT branch ignored.
      ready = 1'b0; base = cap32.size();
      do_start();
      run_cyc(1'b0, 1'b1, 1'b0, 1'b0);
      run_cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b1, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b0, 1'b0);
      run_cyc(1'b1, 1'b1, 1'b0, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b0, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b0, 1'b0);
      br_instr = 1'b1; br_miss = 1'b1;
      tick();
      tick();
      idle_inputs();
      ready = 1'b1;
      wait_done("orphan_done");
      check_report("orphan", base, 7, 2, 1, 1'b0);

      // Saturation on the 4-bit instance: 20 branch cycles.
      base = cap32.size();
      do_start();
      for (int i = 0; i < 20; i++) run_cyc(1'b1, 1'b0, i == 19, 1'b0);
      wait_done("sat_done");
      check_report("sat32", base, 24, 20, 0, 1'b0);
      check_report("sat4", base, 15, 15, 0, 1'b1);
      chk("sat4_flag", 64'(sat4), 64'd1);
      chk("sat32_flag", 64'(sat), 64'd0);

      // Next start clears sat; start inside RUN ignored; stop+HALT is one end event.
      base = cap32.size();
      do_start();
      chk("sat4_clear", 64'(sat4), 64'd0);
      run_cyc(1'b0, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      run_cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_cyc(1'b1, 1'b0, 1'b1, 1'b1);
      repeat (DRAIN_CYC) tick();
      chk("both_end_busy", 64'(busy), 64'd0);
      chk("both_end_valid", 64'(valid), 64'd1);
      wait_done("both_end_done");
      check_report("both_end", base, 7, 2, 0, 1'b0);

      // Reset in DRAIN, then reset in REPORT at index 1.
      do_start();
      run_cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_cyc(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      do_reset("rst_drain");
      ready = 1'b0;
      do_start();
      run_cyc(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (DRAIN_CYC + 1) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("pre_rst_idx", 64'(idx), 64'd1);
      do_reset("rst_report");

      // Fresh run after reset.
      ready = 1'b1; base = cap32.size();
      do_start();
      run_cyc(1'b1, 1'b1, 1'b1, 1'b0);
      wait_done("fresh_done");
      check_report("fresh", base, 5, 1, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
